// File: rtl/asip_pkg.sv
// -----------------------------------------------------------------------------
// asip_pkg
// Shared definitions for the fetch stage and the control unit that decodes
// its IF/ID fields: fetch FSM state encoding, instruction field positions,
// op/inst encodings and the bubble word.
// -----------------------------------------------------------------------------
package asip_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_BLOCKED,
        S_HALT
    } fetch_state_e;

    // Instruction field positions (32-bit instruction word).
    localparam int OP_MSB   = 31;
    localparam int INST_MSB = 29;
    localparam int VF_BIT   = 27;

    // op / inst encodings the fetch stage itself must recognise.
    localparam logic [1:0] OP_SYS    = 2'b00;
    localparam logic [1:0] INST_HALT = 2'b11;
    localparam logic [1:0] OP_NOP    = 2'b01;
    localparam logic [1:0] INST_NOP  = 2'b11;

    // Bubble word: op=01, inst=11 is an unused encoding with no side effects.
    localparam logic [31:0] NOP_INSTR = 32'h7000_0000;

    function automatic logic is_halt(input logic [31:0] instr);
        return (instr[OP_MSB -: 2] == OP_SYS) && (instr[INST_MSB -: 2] == INST_HALT);
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with a one-entry skid buffer.
//   clk, rst        : clock, asynchronous active-high reset
//   stall           : freeze IF/ID; an incoming word is parked in the buffer
//   flush           : load a bubble into IF/ID and discard the buffer
//   in_valid        : a fetched word is being delivered this cycle
//   in_instr, in_pc : the delivered word and its PC
//   id_valid, id_instr, id_pc : IF/ID contents (bubble = NOP word, valid=0)
// Priority: flush > stall > drain buffer > new word > bubble.
// -----------------------------------------------------------------------------
module if_id_reg #(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = asip_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc
);

    logic               id_valid_q,  id_valid_d;
    logic [INSTR_W-1:0] id_instr_q,  id_instr_d;
    logic [ADDR_W-1:0]  id_pc_q,     id_pc_d;
    logic               buf_valid_q, buf_valid_d;
    logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
    logic [ADDR_W-1:0]  buf_pc_q,    buf_pc_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        id_valid_d  = id_valid_q;
        id_instr_d  = id_instr_q;
        id_pc_d     = id_pc_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;

        if (flush) begin
            id_valid_d  = 1'b0;
            id_instr_d  = NOP_INSTR;
            buf_valid_d = 1'b0;
        end else if (stall) begin
            // IF/ID frozen; a word arriving now is parked. The fetch FSM never
            // requests while the buffer is full, so this cannot overwrite.
            if (in_valid) begin
                buf_valid_d = 1'b1;
                buf_instr_d = in_instr;
                buf_pc_d    = in_pc;
            end
        end else if (buf_valid_q) begin
            id_valid_d  = 1'b1;
            id_instr_d  = buf_instr_q;
            id_pc_d     = buf_pc_q;
            buf_valid_d = 1'b0;
        end else if (in_valid) begin
            id_valid_d = 1'b1;
            id_instr_d = in_instr;
            id_pc_d    = in_pc;
        end else begin
            // Previous instruction was consumed and nothing replaced it.
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            id_valid_q  <= 1'b0;
            id_instr_q  <= NOP_INSTR;
            id_pc_q     <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            id_valid_q  <= id_valid_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    // NOTE: the buffer payload is deliberately left out of reset; it is only
    // ever read while buf_valid_q is set, and buf_valid_q is reset.
    always_ff @(posedge clk) begin
        buf_instr_q <= buf_instr_d;
        buf_pc_q    <= buf_pc_d;
    end

    assign id_valid = id_valid_q;
    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, drives a req/ack instruction-memory
// port, and holds the IF/ID register whose fields feed the control unit.
//   clk, rst              : clock, asynchronous active-high reset
//   start, start_pc       : leave IDLE/HALT and fetch from start_pc
//   imem_req, imem_addr   : request held until ack; addr equals pc
//   imem_ack, imem_rdata  : one-cycle ack with the fetched word
//   stall                 : downstream hazard, freeze IF/ID
//   br_taken, br_target   : redirect with squash of in-flight fetch
//   id_valid/id_instr/id_pc : IF/ID contents
//   id_op/id_inst/id_vf   : decoded field slices of id_instr
//   halted                : stage is in HALT
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_STEP   = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = asip_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [1:0]         id_op,
    output logic [1:0]         id_inst,
    output logic               id_vf,
    output logic               halted
);

    import asip_pkg::*;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              squash_q, squash_d;
    logic              req_q, req_d;
    logic              halted_q, halted_d;

    logic fetching;
    logic active;
    logic word_is_halt;
    logic deliver;
    logic flush;

    assign fetching     = (state_q == S_FETCH) || (state_q == S_WAIT);
    assign active       = fetching || (state_q == S_BLOCKED);
    assign word_is_halt = is_halt(imem_rdata);
    // Redirects are only meaningful while the stage is running.
    assign flush        = br_taken && active;
    assign deliver      = fetching && imem_ack && !br_taken && !squash_q && !word_is_halt;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        squash_d = squash_q;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                // start wins over a simultaneous br_taken, which is ignored here.
                if (start) begin
                    pc_d    = start_pc;
                    state_d = S_FETCH;
                end
            end
            S_FETCH, S_WAIT: begin
                if (br_taken) begin
                    pc_d = br_target;
                    // The request is already visible to memory in FETCH too, so
                    // a late ack must be discarded; a same-cycle ack is just dropped.
                    squash_d = !imem_ack;
                    state_d  = imem_ack ? S_FETCH : S_WAIT;
                end else if (imem_ack) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = S_FETCH;
                    end else if (word_is_halt) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(PC_STEP);
                        state_d = stall ? S_BLOCKED : S_FETCH;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_BLOCKED: begin
                if (br_taken) begin
                    pc_d    = br_target;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    // Buffer drains into IF/ID on this same edge.
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_d    = (state_d == S_FETCH) || (state_d == S_WAIT);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            squash_q <= 1'b0;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
            req_q    <= req_d;
            halted_q <= halted_d;
        end
    end

    if_id_reg #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .flush   (flush),
        .in_valid(deliver),
        .in_instr(imem_rdata),
        .in_pc   (pc_q),
        .id_valid(id_valid),
        .id_instr(id_instr),
        .id_pc   (id_pc)
    );

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign halted    = halted_q;
    assign id_op     = id_instr[OP_MSB -: 2];
    assign id_inst   = id_instr[INST_MSB -: 2];
    assign id_vf     = id_instr[VF_BIT];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h7000_0000;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        start      = 1'b0;
    logic [31:0] start_pc   = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack   = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall      = 1'b0;
    logic        br_taken   = 1'b0;
    logic [31:0] br_target  = '0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [1:0]  id_op;
    logic [1:0]  id_inst;
    logic        id_vf;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_op(id_op), .id_inst(id_inst), .id_vf(id_vf),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0] mem_ovr [logic [31:0]];
    logic [31:0] req_log [$];
    int          wait_cnt  = -1;
    int          fixed_lat = 1;
    bit          lat_rand  = 1'b0;
    logic        req_prev  = 1'b0;
    logic [31:0] lat_addr  = '0;

    // Default contents never decode as HALT (bit 31 forced high).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return ((a * 32'h9E37_79B1) ^ 32'h1357_9BDF) | 32'h8000_0000;
    endfunction

    // Responds on the falling edge; the word returned is the one at the
    // address presented when the request was first seen.
    always @(negedge clk) begin
        if (imem_req && (!req_prev || imem_ack)) req_log.push_back(imem_addr);
        req_prev = imem_req;
        imem_ack = 1'b0;
        if (!imem_req) begin
            wait_cnt = -1;
        end else begin
            if (wait_cnt < 0) begin
                wait_cnt = lat_rand ? int'($urandom_range(0, 3)) : fixed_lat;
                lat_addr = imem_addr;
            end
            if (wait_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(lat_addr);
                wait_cnt   = -1;
            end else begin
                wait_cnt--;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; stall = 1'b0; br_taken = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        req_log.delete();
    endtask

    task automatic pulse_start(input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; start_pc = a;
        @(negedge clk);
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++; if ({imem_req, id_valid, halted} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: req/valid/halted=%b want 000", {imem_req, id_valid, halted}); end
        n_tests++; if (id_instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", id_instr, NOP); end
        n_tests++; if ({id_pc, imem_addr} !== 64'h0) begin n_fail++; $display("FAIL reset_pc: id_pc=%h addr=%h want 0", id_pc, imem_addr); end
        n_tests++; if ({id_op, id_inst, id_vf} !== 5'b01_11_0) begin n_fail++; $display("FAIL reset_fields: got %b want 01110", {id_op, id_inst, id_vf}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc = 32'h100;
        logic [31:0] w;
        fixed_lat = 1; lat_rand = 1'b0;
        do_reset();
        pulse_start(32'h100);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            n_tests++; if (id_valid !== imem_ack) begin n_fail++; $display("FAIL seq_valid_latency cyc%0d: id_valid=%b want %b", i, id_valid, imem_ack); end
            if (imem_ack) begin
                w = mem_word(exp_pc);
                n_tests++; if ({id_pc, id_instr} !== {exp_pc, w}) begin n_fail++; $display("FAIL seq_word: pc=%h instr=%h want pc=%h instr=%h", id_pc, id_instr, exp_pc, w); end
                n_tests++; if ({id_op, id_inst, id_vf} !== {w[31:30], w[29:28], w[27]}) begin n_fail++; $display("FAIL seq_fields: got %b want %b", {id_op, id_inst, id_vf}, {w[31:30], w[29:28], w[27]}); end
                exp_pc += 32'd4;
            end
        end
        n_tests++;
        if (req_log.size() < 3) begin n_fail++; $display("FAIL seq_req_count: got %0d want >=3", req_log.size()); end
        else if ({req_log[0], req_log[1], req_log[2]} !== {32'h100, 32'h104, 32'h108}) begin
            n_fail++; $display("FAIL seq_req_addr: got %h %h %h want 100 104 108", req_log[0], req_log[1], req_log[2]);
        end
    endtask

    task automatic test_stall_buffer();
        bit seen = 1'b0;
        fixed_lat = 1; lat_rand = 1'b0;
        do_reset();
        mem_ovr[32'h300] = 32'h8000_0000;
        @(negedge clk);
        stall = 1'b1;
        pulse_start(32'h300);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = imem_ack;
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL stall_ack_timeout: no ack within 10 cycles"); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            n_tests++; if ({imem_req, id_valid, id_instr} !== {1'b0, 1'b0, NOP}) begin n_fail++; $display("FAIL stall_hold cyc%0d: req=%b valid=%b instr=%h want 0 0 %h", i, imem_req, id_valid, id_instr, NOP); end
        end
        n_tests++; if (req_log.size() != 1) begin n_fail++; $display("FAIL stall_no_new_req: %0d requests want 1", req_log.size()); end
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk); #1;
        n_tests++; if ({id_valid, id_instr, id_pc} !== {1'b1, 32'h8000_0000, 32'h300}) begin n_fail++; $display("FAIL stall_drain: valid=%b instr=%h pc=%h want 1 80000000 300", id_valid, id_instr, id_pc); end
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h304}) begin n_fail++; $display("FAIL stall_resume: req=%b addr=%h want 1 304", imem_req, imem_addr); end
        mem_ovr.delete();
    endtask

    task automatic test_branch_squash();
        bit got = 1'b0;
        fixed_lat = 3; lat_rand = 1'b0;
        do_reset();
        mem_ovr[32'h500] = 32'hC123_4567;
        pulse_start(32'h500);
        @(negedge clk);
        br_taken = 1'b1; br_target = 32'h40;
        @(posedge clk); #1;
        n_tests++; if ({id_valid, id_instr} !== {1'b0, NOP}) begin n_fail++; $display("FAIL br_flush: valid=%b instr=%h want 0 %h", id_valid, id_instr, NOP); end
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin n_fail++; $display("FAIL br_redirect: req=%b addr=%h want 1 40", imem_req, imem_addr); end
        @(negedge clk);
        br_taken = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(posedge clk); #1;
            got = id_valid;
            n_tests++; if (id_instr === 32'hC123_4567) begin n_fail++; $display("FAIL br_squash: dropped word %h reached IF/ID", id_instr); end
        end
        n_tests++; if (!got) begin n_fail++; $display("FAIL br_timeout: no delivery after redirect"); end
        n_tests++; if ({id_pc, id_instr} !== {32'h40, mem_word(32'h40)}) begin n_fail++; $display("FAIL br_target_word: pc=%h instr=%h want 40 %h", id_pc, id_instr, mem_word(32'h40)); end
        n_tests++; if (req_log.size() < 2 || req_log[1] !== 32'h40) begin n_fail++; $display("FAIL br_next_req: log size %0d, second addr not 40", req_log.size()); end
        mem_ovr.delete();
    endtask

    task automatic test_halt();
        bit got = 1'b0;
        fixed_lat = 1; lat_rand = 1'b0;
        do_reset();
        mem_ovr[32'h600] = 32'h3000_0000;
        pulse_start(32'h600);
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            got = halted;
        end
        n_tests++; if (!got) begin n_fail++; $display("FAIL halt_timeout: halted never rose"); end
        n_tests++; if ({imem_req, id_valid, id_instr} !== {1'b0, 1'b0, NOP}) begin n_fail++; $display("FAIL halt_state: req=%b valid=%b instr=%h want 0 0 %h", imem_req, id_valid, id_instr, NOP); end
        @(negedge clk);
        br_taken = 1'b1; br_target = 32'h80;
        @(posedge clk); #1;
        n_tests++; if ({halted, imem_req} !== 2'b10) begin n_fail++; $display("FAIL halt_br_ignored: halted=%b req=%b want 1 0", halted, imem_req); end
        @(negedge clk);
        start = 1'b1; start_pc = 32'h200;
        @(posedge clk); #1;
        n_tests++; if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin n_fail++; $display("FAIL halt_restart: halted=%b req=%b addr=%h want 0 1 200", halted, imem_req, imem_addr); end
        @(negedge clk);
        start = 1'b0; br_taken = 1'b0;
        mem_ovr.delete();
    endtask

    task automatic test_wrap();
        bit got = 1'b0;
        fixed_lat = 0; lat_rand = 1'b0;
        do_reset();
        pulse_start(32'hFFFF_FFFC);
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            got = id_valid;
        end
        n_tests++; if (!got || id_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first: valid=%b pc=%h want 1 fffffffc", got, id_pc); end
        @(posedge clk); #1;
        n_tests++; if (req_log.size() < 2 || req_log[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr: log size %0d, second addr not 00000000", req_log.size()); end
    endtask

    task automatic test_reset_mid_wait();
        fixed_lat = 5; lat_rand = 1'b0;
        do_reset();
        pulse_start(32'h700);
        @(negedge clk);
        @(negedge clk);
        #2;
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rstw_pre: req=%b want 1", imem_req); end
        rst = 1'b1;
        #1;
        n_tests++; if ({imem_req, id_valid, halted, imem_addr} !== {3'b000, 32'h0}) begin n_fail++; $display("FAIL rstw_ctrl: req=%b valid=%b halted=%b addr=%h want 0 0 0 0", imem_req, id_valid, halted, imem_addr); end
        n_tests++; if ({id_instr, id_pc, id_op, id_inst} !== {NOP, 32'h0, 2'b01, 2'b11}) begin n_fail++; $display("FAIL rstw_id: instr=%h pc=%h op=%b inst=%b want %h 0 01 11", id_instr, id_pc, id_op, id_inst, NOP); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Model: the stream of instructions leaving IF/ID is the memory contents
    // at consecutive PCs from the last start/redirect address.
    task automatic test_random();
        logic [31:0] exp_pc = 32'h1000;
        logic        pre_valid;
        logic [31:0] pre_instr, pre_pc;
        int          consumed = 0;
        lat_rand = 1'b1;
        do_reset();
        pulse_start(32'h1000);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            stall     = ($urandom_range(0, 2) == 0);
            br_taken  = ($urandom_range(0, 19) == 0);
            br_target = 32'($urandom_range(0, 1023)) << 2;
            pre_valid = id_valid; pre_instr = id_instr; pre_pc = id_pc;
            @(posedge clk); #1;
            if (!stall && pre_valid) begin
                n_tests++; if ({pre_pc, pre_instr} !== {exp_pc, mem_word(exp_pc)}) begin n_fail++; $display("FAIL rand_stream cyc%0d: pc=%h instr=%h want pc=%h instr=%h", cyc, pre_pc, pre_instr, exp_pc, mem_word(exp_pc)); end
                exp_pc += 32'd4;
                consumed++;
            end
            if (br_taken) begin
                n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rand_flush cyc%0d: id_valid=%b want 0", cyc, id_valid); end
                exp_pc = br_target;
            end else if (stall) begin
                n_tests++; if ({id_valid, id_instr, id_pc} !== {pre_valid, pre_instr, pre_pc}) begin n_fail++; $display("FAIL rand_stall_hold cyc%0d: %b %h %h want %b %h %h", cyc, id_valid, id_instr, id_pc, pre_valid, pre_instr, pre_pc); end
            end
        end
        @(negedge clk);
        stall = 1'b0; br_taken = 1'b0;
        n_tests++; if (consumed < 20) begin n_fail++; $display("FAIL rand_progress: %0d instructions consumed want >=20", consumed); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_buffer();
        test_branch_squash();
        test_halt();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the control unit.
- Owns the PC and drives a request/acknowledge instruction-memory port.
- Holds the IF/ID pipeline register and splits the held word into the op, inst and VF fields the control unit decodes.
- Handles stall, branch redirect with squash, and halt/restart.

Parameters:
- ADDR_W, 32, PC and memory address width.
- INSTR_W, 32, instruction width.
- PC_STEP, 4, PC increment per sequential fetch.
- NOP_INSTR, 32'h7000_0000, bubble word; op=01, inst=11 is an unused encoding with no side effects.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; leaves IDLE/HALT and begins fetching at start_pc.
- start_pc  in  ADDR_W  restart address.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  ADDR_W  fetch address, equal to pc while req is high.
- imem_ack  in  1  one-cycle pulse; rdata valid in that cycle.
- imem_rdata  in  INSTR_W  fetched word.
- stall  in  1  downstream hazard; freeze the IF/ID register.
- br_taken  in  1  redirect request from the jump logic.
- br_target  in  ADDR_W  redirect address.
- id_valid  out  1  IF/ID holds a real instruction.
- id_instr  out  INSTR_W  IF/ID word; NOP_INSTR when invalid.
- id_pc  out  ADDR_W  PC of id_instr.
- id_op  out  2  id_instr[31:30].
- id_inst  out  2  id_instr[29:28].
- id_vf  out  1  id_instr[27]; vector flag.
- halted  out  1  high in HALT.

Behaviour:
- Reset (async, rst=1), registers take these values immediately:
  - state=IDLE, pc=0, imem_req=0.
  - id_valid=0, id_instr=NOP_INSTR, id_pc=0.
  - buffer empty, squash=0, halted=0.
- Field outputs are combinational slices of id_instr, so after reset they show op=01, inst=11, vf=0.
- States:
  - IDLE: req=0. On start: pc<=start_pc, go to FETCH.
  - FETCH: req=1, addr=pc. Next cycle go to WAIT. If ack arrives in the same cycle, treat it as WAIT-with-ack.
  - WAIT: req held high, addr=pc constant. On ack:
    - If squash: drop the data, clear squash, go to FETCH (pc already redirected).
    - Else if the word is HALT (op=00, inst=11): load it as NOP (id_valid=0), go to HALT, pc unchanged.
    - Else deliver the word (see below), pc<=pc+PC_STEP, go to FETCH. If the buffer became full, go to BLOCKED instead.
  - BLOCKED: req=0. When stall=0, the buffer drains into IF/ID, then go to FETCH.
  - HALT: req=0, halted=1. On start: pc<=start_pc, go to FETCH. Halt does not flush the IF/ID register.
- Delivery:
  - With stall=0, the acked word loads IF/ID next edge: id_valid=1, id_instr=rdata, id_pc=pc.
  - With stall=1, it goes to a one-entry buffer (word and pc).
- Stall: IF/ID holds every field unchanged. Fetch latency, ack to id_valid, is 1 cycle when not stalled.
- No new request is issued while the buffer is full; the buffer never overflows.
- Branch (br_taken=1, has priority over stall):
  - pc<=br_target, IF/ID<=NOP with id_valid=0, buffer cleared.
  - If in WAIT without ack this cycle, set squash. If ack arrives in the same cycle, drop that word, no squash.
  - From BLOCKED, go to FETCH.
  - br_taken in IDLE or HALT is ignored.
- Simultaneous start and br_taken in HALT: start wins.
- PC wraps modulo 2^ADDR_W without error.
- Reset during WAIT abandons the request. The memory must tolerate a dropped req.

Decomposition:
- Shared package (asip_pkg): state enum (IDLE, FETCH, WAIT, BLOCKED, HALT); field bit positions OP_MSB=31, INST_MSB=29, VF_BIT=27; op/inst encodings including HALT (00,11); NOP_INSTR.
- One sub-module, if_id_reg: the stall/flush pipeline register plus the one-entry skid buffer.

Test Plan:
- Reset, then start with start_pc=0x100, memory acks after 1 cycle -> fetch addresses 0x100, 0x104, 0x108 in order; id_op/id_inst match each word; id_valid high 1 cycle after each ack.
- stall=1 held 3 cycles while an ack of word 0x8000_0000 arrives -> IF/ID unchanged, word buffered, no new req; release stall -> id_instr=0x8000_0000 on the next edge, then fetch resumes at pc+4.
- br_taken with target 0x40 while in WAIT, ack 2 cycles later -> acked word never appears on id_*; the next req addr is 0x40; id_valid=0 for the flush cycle.
- Fetch word 0x3000_0000 (HALT) -> halted=1, req=0, id_valid=0; start with start_pc=0x200 -> req addr=0x200.
- pc=0xFFFF_FFFC, sequential fetch -> next addr is 0x0000_0000.
- Assert rst mid-WAIT -> all outputs at reset values within the same cycle; id_instr=0x7000_0000, req=0.
